// File: rtl/multi_digit_seg_counter.sv
`default_nettype none
// ============================================================================
// multi_digit_seg_counter : prescaled up/down BCD counter with a scanned
//                           7-segment display driver.
// Revision 1.0
// ============================================================================
module multi_digit_seg_counter #(
  parameter int               DIGITS    = 4,
  parameter int               CNT_W     = 24,
  parameter logic [CNT_W-1:0] MAX_COUNT = 24'd10_000_000,
  parameter int               SCAN_DIV  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up_dn,
  input  logic                clear,
  input  logic [CNT_W-1:0]    compare_in,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [6:0]          segments,
  output logic [DIGITS-1:0]   digit_sel,
  output logic                tick,
  output logic                wrap
);

  localparam int                IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int                SCAN_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [SCAN_W-1:0] C_LAST_SCAN = SCAN_W'(SCAN_DIV - 1);
  localparam logic [6:0]        C_SEG_ZERO  = 7'h3F;

  logic [CNT_W-1:0]             presc_q, presc_d;
  logic [DIGITS-1:0][3:0]       digit_q, digit_d;
  logic                         tick_q, tick_d;
  logic                         wrap_q, wrap_d;
  logic [SCAN_W-1:0]            scan_q, scan_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DIGITS-1:0]            sel_q, sel_d;
  logic [6:0]                   seg_q, seg_d;

  logic [CNT_W-1:0]             w_term;
  logic [DIGITS-1:0][3:0]       w_step;
  logic                         w_step_wrap;
  logic                         w_carry;
  logic [3:0]                   w_cur_digit;

  assign w_term = (compare_in == '0) ? MAX_COUNT : compare_in;

  // Ripple carry/borrow through the digits; a carry out of the top digit is a full wrap.
  always_comb begin
    w_step  = digit_q;
    w_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (up_dn) begin
          if (digit_q[i] == 4'd9) begin
            w_step[i] = 4'd0;
          end else begin
            w_step[i] = digit_q[i] + 4'd1;
            w_carry   = 1'b0;
          end
        end else begin
          if (digit_q[i] == 4'd0) begin
            w_step[i] = 4'd9;
          end else begin
            w_step[i] = digit_q[i] - 4'd1;
            w_carry   = 1'b0;
          end
        end
      end
    end
    w_step_wrap = w_carry;
  end

  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear) begin
      presc_d = '0;
      digit_d = '0;
    end else if (en) begin
      if (presc_q >= w_term) begin
        presc_d = '0;
        tick_d  = 1'b1;
        digit_d = w_step;
        wrap_d  = w_step_wrap;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign w_cur_digit = digit_q[idx_q];

  // Scan runs free of en/clear; select and segments are registered together.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == C_LAST_SCAN) begin
      scan_d = '0;
      idx_d  = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    sel_d        = '0;
    sel_d[idx_q] = 1'b1;
    case (w_cur_digit)
      4'd0:    seg_d = 7'h3F;
      4'd1:    seg_d = 7'h06;
      4'd2:    seg_d = 7'h5B;
      4'd3:    seg_d = 7'h4F;
      4'd4:    seg_d = 7'h66;
      4'd5:    seg_d = 7'h6D;
      4'd6:    seg_d = 7'h7D;
      4'd7:    seg_d = 7'h07;
      4'd8:    seg_d = 7'h7F;
      4'd9:    seg_d = 7'h6F;
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      digit_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      sel_q   <= DIGITS'(1);
      seg_q   <= C_SEG_ZERO;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd_out   = digit_q;
  assign segments  = seg_q;
  assign digit_sel = sel_q;
  assign tick      = tick_q;
  assign wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_seg_counter.sv
`default_nettype none
// ============================================================================
// tb_multi_digit_seg_counter : scoreboard bench for multi_digit_seg_counter.
// Revision 1.0
// ============================================================================
module tb_multi_digit_seg_counter;

  logic        clk;
  logic        reset;
  logic        en;
  logic        up_dn;
  logic        clear;
  logic [23:0] compare_in;
  logic [15:0] bcd_out;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;
  logic        tick;
  logic        wrap;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mval     = 0;

  multi_digit_seg_counter #(
    .DIGITS   (4),
    .CNT_W    (24),
    .SCAN_DIV (2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_dn      (up_dn),
    .clear      (clear),
    .compare_in (compare_in),
    .bcd_out    (bcd_out),
    .segments   (segments),
    .digit_sel  (digit_sel),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic push_step(input logic up);
    exp_t e;
    if (up) begin
      e.wrap = (mval == 9999);
      mval   = (mval + 1) % 10000;
    end else begin
      e.wrap = (mval == 0);
      mval   = (mval + 9999) % 10000;
    end
    e.bcd = to_bcd(mval);
    q.push_back(e);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(output int n, input int bound);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!tick && n < bound);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, q.size(), 0);
  endtask

  // Monitor: every tick pops one expected step; wrap must never appear without tick.
  always @(negedge clk) begin
    if (!reset) begin
      if (tick) begin
        if (q.size() == 0) begin
          chk("unexpected_tick", 32'(tick), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("step_bcd", 32'(bcd_out), 32'(e.bcd));
          chk("step_wrap", 32'(wrap), 32'(e.wrap));
        end
      end else begin
        chk("wrap_idle", 32'(wrap), 0);
      end
    end
  end

  logic [3:0] exp_sel [4];
  logic [6:0] exp_seg [4];

  initial begin
    int   n;
    logic [3:0] prev;

    exp_sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_seg = '{7'h66, 7'h4F, 7'h5B, 7'h06};

    reset      = 1'b1;
    en         = 1'b0;
    up_dn      = 1'b1;
    clear      = 1'b0;
    compare_in = 24'd3;
    cycles(3);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_sel", 32'(digit_sel), 1);
    chk("rst_seg", 32'(segments), 32'h3F);

    // Up count, period term+1 = 4
    reset = 1'b0;
    for (int i = 0; i < 10; i++) push_step(1'b1);
    en = 1'b1;
    wait_tick(n, 20);
    chk("first_tick_lat", n, 4);
    wait_tick(n, 20);
    chk("tick_period", n, 4);
    wait_drain("up10_drain", 100);
    chk("up10_bcd", 32'(bcd_out), 32'h0010);

    // Pause mid-period: no step lost or duplicated
    push_step(1'b1);
    cycles(2);
    en = 1'b0;
    cycles(10);
    chk("pause_hold", 32'(bcd_out), 32'h0010);
    en = 1'b1;
    wait_tick(n, 20);
    chk("pause_resume_lat", n, 2);

    // Clear on the terminal edge beats the step
    cycles(3);
    clear = 1'b1;
    cycles(1);
    chk("clr_bcd", 32'(bcd_out), 0);
    chk("clr_tick", 32'(tick), 0);
    clear = 1'b0;
    mval  = 0;
    push_step(1'b1);
    wait_tick(n, 20);
    chk("after_clr_lat", n, 4);

    // Async reset between edges, one edge before a pending step
    cycles(3);
    chk("pre_rst_bcd", 32'(bcd_out), 32'h0001);
    reset = 1'b1;
    #1;
    chk("arst_bcd", 32'(bcd_out), 0);
    chk("arst_tick", 32'(tick), 0);
    chk("arst_wrap", 32'(wrap), 0);
    chk("arst_sel", 32'(digit_sel), 1);
    chk("arst_seg", 32'(segments), 32'h3F);
    q.delete();
    mval  = 0;
    up_dn = 1'b0;
    push_step(1'b0);
    push_step(1'b0);
    #1;
    reset = 1'b0;
    wait_tick(n, 20);
    chk("rst_resume_lat", n, 4);
    wait_drain("down_drain", 40);
    chk("down_bcd", 32'(bcd_out), 32'h9998);

    // Back up through 9999 to a full wrap
    up_dn = 1'b1;
    push_step(1'b1);
    push_step(1'b1);
    wait_drain("wrap_up_drain", 40);
    chk("wrap_up_bcd", 32'(bcd_out), 0);
    cycles(1);
    chk("wrap_one_cycle", 32'(wrap), 0);

    // Lowering compare below the prescaler rolls over on the next edge
    compare_in = 24'd20;
    push_step(1'b1);
    cycles(9);
    compare_in = 24'd3;
    wait_tick(n, 40);
    chk("cmp_lower_lat", n, 1);

    // Count to 1234 quickly, then freeze for the scan check
    compare_in = 24'd1;
    for (int i = 0; i < 1233; i++) push_step(1'b1);
    wait_drain("to1234_drain", 3000);
    en = 1'b0;
    chk("bcd_1234", 32'(bcd_out), 32'h1234);

    prev = digit_sel;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (digit_sel == 4'b0001 && prev != 4'b0001) break;
      prev = digit_sel;
    end while (n < 20);
    chk("scan_sync", 32'(digit_sel), 1);
    for (int j = 0; j < 8; j++) begin
      chk("scan_sel", 32'(digit_sel), 32'(exp_sel[j/2]));
      chk("scan_seg", 32'(segments), 32'(exp_seg[j/2]));
      @(negedge clk);
      #1;
    end
    chk("scan_wrap_sel", 32'(digit_sel), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
